// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared op/state encodings and stall levels for ex_muldiv
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// rtl/ex_muldiv_div_core.sv - unsigned restoring divider, one quotient bit per cycle
module ex_muldiv_div_core #(
  parameter int DW  = 32,
  parameter int CYC = DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] dsr_q;
  logic [DW:0]   rem_sh;
  logic [DW:0]   diff;
  logic          take;

  // Trial subtraction is one bit wider so the borrow tells us whether to restore.
  assign rem_sh = {rem_q, quo_q[DW-1]};
  assign diff   = rem_sh - {1'b0, dsr_q};
  assign take   = ~diff[DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      quo_q   <= dividend;
      rem_q   <= '0;
      dsr_q   <= divisor;
    end else if (running) begin
      quo_q <= {quo_q[DW-2:0], take};
      rem_q <= take ? diff[DW-1:0] : rem_sh[DW-1:0];
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

  assign done      = running && (cnt == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage multi-cycle mul/div unit owning HI/LO
// FAST_MUL_EN selects a single-cycle multiplier; divide is always iterative.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DW      = 32,
  parameter int DIV_CYC = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] src1,
  input  logic [DW-1:0] src2,
  input  logic          hi_we,
  input  logic          lo_we,
  input  logic [DW-1:0] wdata,
  output logic          stallreq,
  output logic          busy,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  md_state_e       state;
  md_op_e          op_e;
  logic            signed_op;
  logic            is_div;
  logic            s1_neg;
  logic            s2_neg;
  logic [DW-1:0]   mag1;
  logic [DW-1:0]   mag2;
  logic            div_zero;
  logic            div_go;

  logic [2*DW-1:0] acc;
  logic [DW-1:0]   mcand;
  logic            neg_res;
  logic            neg_rem;
  logic            use_acc;

  logic            div_done;
  logic [DW-1:0]   quo;
  logic [DW-1:0]   rem;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo_s;
  logic [DW-1:0]   rem_s;
  logic [2*DW-1:0] res;

  assign op_e      = md_op_e'(op);
  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign is_div    = (op_e == MD_DIVU) || (op_e == MD_DIV);
  assign s1_neg    = signed_op & src1[DW-1];
  assign s2_neg    = signed_op & src2[DW-1];
  assign mag1      = s1_neg ? (~src1 + 1'b1) : src1;
  assign mag2      = s2_neg ? (~src2 + 1'b1) : src2;
  assign div_zero  = (src2 == '0);
  assign div_go    = (state == ST_IDLE) && start && is_div && !div_zero;

  ex_muldiv_div_core #(
    .DW  (DW),
    .CYC (DIV_CYC)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_go),
    .dividend  (mag1),
    .divisor   (mag2),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

`ifndef FAST_MUL_EN
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] MUL_LAST = CW'(DW - 1);

  logic [CW-1:0]   cnt;
  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] mul_step;

  // acc holds {partial product, unconsumed multiplier bits}; both shift right together.
  assign mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_step = {mul_sum, acc[DW-1:1]};
`endif

  assign prod  = neg_res ? (~acc + 1'b1) : acc;
  assign quo_s = neg_res ? (~quo + 1'b1) : quo;
  assign rem_s = neg_rem ? (~rem + 1'b1) : rem;
  assign res   = use_acc ? prod : {rem_s, quo_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      hi_o    <= '0;
      lo_o    <= '0;
      acc     <= '0;
      mcand   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      use_acc <= 1'b0;
`ifndef FAST_MUL_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifndef FAST_MUL_EN
            cnt     <= '0;
`endif
            mcand   <= mag1;
            neg_res <= s1_neg ^ s2_neg;
            neg_rem <= s1_neg;
            use_acc <= !is_div;
            if (!is_div) begin
              acc   <= {{DW{1'b0}}, mag2};
              state <= ST_MUL;
            end else if (div_zero) begin
              // Divide by zero skips iteration: HI keeps the raw dividend, LO all ones.
              acc     <= {src1, {DW{1'b1}}};
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              use_acc <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_DIV;
            end
          end else begin
            if (hi_we) hi_o <= wdata;
            if (lo_we) lo_o <= wdata;
          end
        end
        ST_MUL: begin
`ifdef FAST_MUL_EN
          acc   <= (2*DW)'(mcand) * (2*DW)'(acc[DW-1:0]);
          state <= ST_DONE;
`else
          acc <= mul_step;
          cnt <= cnt + 1'b1;
          if (cnt == MUL_LAST) state <= ST_DONE;
`endif
        end
        ST_DIV: begin
          if (div_done) state <= ST_DONE;
        end
        ST_DONE: begin
          hi_o  <= res[2*DW-1:DW];
          lo_o  <= res[DW-1:0];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq = NO_STOP;
    case (state)
      ST_IDLE: stallreq = start ? STOP : NO_STOP;
      ST_MUL:  stallreq = STOP;
      ST_DIV:  stallreq = STOP;
      ST_DONE: stallreq = NO_STOP;
      default: stallreq = NO_STOP;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv (FAST_MUL_EN aware)
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        stallreq;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int D_STALL = 33;
  localparam int D_LAT   = 34;
`ifdef FAST_MUL_EN
  localparam int M_STALL = 2;
  localparam int M_LAT   = 3;
`else
  localparam int M_STALL = 33;
  localparam int M_LAT   = 34;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  ex_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .stallreq (stallreq),
    .busy     (busy),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a busy->idle transition means results are on hi_o/lo_o.
  initial begin
    logic prev_busy;
    int   stall_cnt;
    int   lat_cnt;
    exp_t e;
    prev_busy = 1'b0;
    stall_cnt = 0;
    lat_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        stall_cnt = 0;
        lat_cnt   = 0;
      end else begin
        if (stallreq) stall_cnt++;
        if (stallreq || busy) lat_cnt++;
        if (prev_busy && !busy) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got hi=%h lo=%h expected none", hi_o, lo_o);
          end else begin
            e = sb_q.pop_front();
            chk("sb_hi", hi_o, e.hi);
            chk("sb_lo", lo_o, e.lo);
            chk("sb_stall", stall_cnt, e.stall);
            chk("sb_latency", lat_cnt, e.lat);
          end
          stall_cnt = 0;
          lat_cnt   = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic hw, input logic mid,
                       input logic [31:0] eh, input logic [31:0] el,
                       input int es, input int lt);
    exp_t e;
    int   n;
    e.hi = eh; e.lo = el; e.stall = es; e.lat = lt;
    sb_q.push_back(e);
    start = 1'b1; op = o; src1 = a; src2 = b;
    hi_we = hw; wdata = hw ? 32'hDEAD_BEEF : 32'h0;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    chk({name, "_hold_hi"}, hi_o, model_hi);
    chk({name, "_hold_lo"}, lo_o, model_lo);
    n = 0;
    if (mid) begin
      repeat (4) @(posedge clk);
      #1;
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      chk({name, "_mid_we_hi"}, hi_o, model_hi);
      chk({name, "_mid_we_lo"}, lo_o, model_lo);
      n = 5;
    end
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_finished"}, {31'b0, busy}, 32'h0);
    model_hi = eh;
    model_lo = el;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stallreq}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_hi", hi_o, 32'hA5A5_A5A5);
    chk("mthi_lo", lo_o, 32'h0);
    lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo_lo", lo_o, 32'h5A5A_5A5A);
    chk("mtlo_hi", hi_o, 32'hA5A5_A5A5);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", hi_o, 32'h0F0F_0F0F);
    chk("mthilo_lo", lo_o, 32'h0F0F_0F0F);

    // Abort a divide with an asynchronous reset around DIV cycle 10.
    start = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_hi", hi_o, 32'h0);
    chk("abort_lo", lo_o, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_stall", {31'b0, stallreq}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_after_hi", hi_o, 32'h0);
    chk("abort_after_lo", lo_o, 32'h0);
    chk("abort_after_busy", {31'b0, busy}, 32'h0);
    model_hi = 32'h0;
    model_lo = 32'h0;

    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd2, 32'd14, D_STALL, D_LAT);
    do_op("divu_mid_we", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1,
          32'h0000_000F, 32'h0FFF_FFFF, D_STALL, D_LAT);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, D_STALL, D_LAT);
    do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0,
          32'h0000_0001, 32'hFFFF_FFFD, D_STALL, D_LAT);
    do_op("mult_m1_2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0,
          32'hFFFF_FFFF, 32'hFFFF_FFFE, M_STALL, M_LAT);
    do_op("multu_ff_2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0,
          32'h0000_0001, 32'hFFFF_FFFE, M_STALL, M_LAT);
    do_op("multu_ff_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
          32'hFFFF_FFFE, 32'h0000_0001, M_STALL, M_LAT);
    do_op("div_by_zero", OP_DIV, 32'h0000_1234, 32'h0, 1'b0, 1'b0,
          32'h0000_1234, 32'hFFFF_FFFF, 1, 2);
    do_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
          32'h0, 32'h8000_0000, D_STALL, D_LAT);
    do_op("mult_with_mthi", OP_MULT, 32'd3, 32'hFFFF_FFFB, 1'b1, 1'b0,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, M_STALL, M_LAT);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
